ncl_mult3_sync_bridge: RTL and testbench

Clocked producer/consumer shell wrapped around the 3x3 NCL multiplier core.
- Accepts binary operands on a valid/ready interface and encodes them to dual-rail.
- Drives the core's DATA/NULL four-phase handshake (Ki/Ko), detects completion on the synchronised product rails, and decodes the 6-bit product into a one-entry output buffer with valid/ready.
- Sits between the synchronous test/SoC fabric and the core; it is the core's only upstream and downstream neighbour.

---
 rtl/ncl_pkg.sv | 69 ++++++
 rtl/ncl_sync_vec.sv | 30 +++
 rtl/ncl_mult3_sync_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_ncl_mult3_sync_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Dual-rail (NCL) types and helpers shared by the 3x3 multiplier bridge.
// Rail pair {r1,r0}: 10 = DATA1, 01 = DATA0, 00 = NULL, 11 = illegal.
package ncl_pkg;

    localparam int MULT3_W = 3;
    localparam int PROD_W  = 6;

    typedef struct packed {
        logic r1;
        logic r0;
    } dual_rail_logic;

    localparam dual_rail_logic NCL_NULL = '{r1: 1'b0, r0: 1'b0};

    typedef dual_rail_logic [MULT3_W-1:0] dr_op_t;
    typedef dual_rail_logic [PROD_W-1:0]  dr_prod_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_DATA,
        ST_NULLP
    } bridge_state_t;

    function automatic dr_op_t dr_encode(input logic [MULT3_W-1:0] v);
        dr_op_t r;
        for (int i = 0; i < MULT3_W; i++) begin
            r[i].r1 = v[i];
            r[i].r0 = ~v[i];
        end
        return r;
    endfunction

    function automatic logic [PROD_W-1:0] dr_decode(input dr_prod_t d);
        logic [PROD_W-1:0] v;
        for (int i = 0; i < PROD_W; i++) begin
            v[i] = d[i].r1;
        end
        return v;
    endfunction

    function automatic logic dr_is_complete(input dr_prod_t d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < PROD_W; i++) begin
            ok = ok & (d[i].r1 ^ d[i].r0);
        end
        return ok;
    endfunction

    function automatic logic dr_is_null(input dr_prod_t d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < PROD_W; i++) begin
            ok = ok & (d[i] == NCL_NULL);
        end
        return ok;
    endfunction

    function automatic logic dr_has_illegal(input dr_prod_t d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < PROD_W; i++) begin
            bad = bad | (d[i].r1 & d[i].r0);
        end
        return bad;
    endfunction

endpackage

// File: rtl/ncl_sync_vec.sv
// Multi-bit flop synchroniser, reset to zero. Each bit is synchronised
// independently; consumers must tolerate inter-bit skew.
module ncl_sync_vec #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_mult3_sync_bridge.sv
// Clocked valid/ready shell around the 3x3 NCL multiplier core: encodes
// operands to dual-rail, runs the Ki/Ko four-phase handshake, buffers the product.
module ncl_mult3_sync_bridge
    import ncl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MULT3_W-1:0] in_a,
    input  logic [MULT3_W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PROD_W-1:0]  out_p,
    output logic               mul_rst,
    output logic               mul_ki,
    output logic [MULT3_W-1:0] mul_a_r1,
    output logic [MULT3_W-1:0] mul_a_r0,
    output logic [MULT3_W-1:0] mul_b_r1,
    output logic [MULT3_W-1:0] mul_b_r0,
    input  logic [PROD_W-1:0]  mul_p_r1,
    input  logic [PROD_W-1:0]  mul_p_r0,
    input  logic               mul_ko,
    output logic               err_timeout,
    output logic               err_rail
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    bridge_state_t      r_state;
    bridge_state_t      w_state_next;
    logic [SYNC_STAGES:0] r_rst_sh;
    dr_op_t             r_a_dr;
    dr_op_t             r_b_dr;
    logic               r_ki;
    logic               r_out_valid;
    logic [PROD_W-1:0]  r_out_p;
    logic               r_data_seen;
    logic               r_null_seen;
    logic               r_ill_seen;
    logic [WD_W-1:0]    r_wd_cnt;
    logic               r_err_timeout;
    logic               r_err_rail;

    logic               w_ko_s;
    logic [2*PROD_W-1:0] w_p_sync;
    dr_prod_t           w_p_dr;
    logic               w_complete;
    logic               w_null;
    logic               w_illegal;
    logic               w_data_cond;
    logic               w_null_cond;
    logic               w_data_ok;
    logic               w_null_ok;
    logic               w_buf_free;
    logic               w_accept;
    logic               w_load;
    logic               w_release;
    logic               w_wd_clr;
    logic               w_wd_arm;

    // Core reset: set with rst, released SYNC_STAGES+1 edges after rst falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_sh <= '1;
        end else begin
            r_rst_sh <= {r_rst_sh[SYNC_STAGES-1:0], 1'b0};
        end
    end

    assign mul_rst = r_rst_sh[SYNC_STAGES];

    ncl_sync_vec #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_ko (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (mul_ko),
        .o_q   (w_ko_s)
    );

    ncl_sync_vec #(
        .WIDTH       (2*PROD_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_p (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   ({mul_p_r1, mul_p_r0}),
        .o_q   (w_p_sync)
    );

    always_comb begin
        for (int i = 0; i < PROD_W; i++) begin
            w_p_dr[i].r1 = w_p_sync[PROD_W+i];
            w_p_dr[i].r0 = w_p_sync[i];
        end
    end

    assign w_complete  = dr_is_complete(w_p_dr);
    assign w_null      = dr_is_null(w_p_dr);
    assign w_illegal   = dr_has_illegal(w_p_dr);
    assign w_data_cond = w_complete & ~w_ko_s;
    assign w_null_cond = w_null & w_ko_s;

    // Conditions must hold on two consecutive samples to ride out skew
    // between independently synchronised bits.
    assign w_data_ok  = w_data_cond & r_data_seen;
    assign w_null_ok  = w_null_cond & r_null_seen;
    assign w_buf_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT:  if (!mul_rst && w_ko_s && w_null) w_state_next = ST_IDLE;
            ST_IDLE:  if (in_valid)                     w_state_next = ST_DATA;
            ST_DATA:  if (w_data_ok && w_buf_free)      w_state_next = ST_NULLP;
            ST_NULLP: if (w_null_ok)                    w_state_next = ST_IDLE;
            default:                                    w_state_next = ST_INIT;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        w_accept  = in_ready & in_valid;
        w_load    = (r_state == ST_DATA) & w_data_ok & w_buf_free;
        w_release = (r_state == ST_NULLP) & w_null_ok;
    end

    // Core-facing rails and Ki change only here, so every transition is a
    // single-edge NULL<->DATA move straight out of flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_dr      <= {MULT3_W{NCL_NULL}};
            r_b_dr      <= {MULT3_W{NCL_NULL}};
            r_ki        <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
        end else begin
            if (w_accept) begin
                r_a_dr <= dr_encode(in_a);
                r_b_dr <= dr_encode(in_b);
            end
            if (w_load) begin
                r_a_dr      <= {MULT3_W{NCL_NULL}};
                r_b_dr      <= {MULT3_W{NCL_NULL}};
                r_ki        <= 1'b0;
                r_out_p     <= dr_decode(w_p_dr);
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_release) begin
                r_ki <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_seen <= 1'b0;
            r_null_seen <= 1'b0;
            r_ill_seen  <= 1'b0;
            r_err_rail  <= 1'b0;
        end else begin
            r_data_seen <= w_data_cond;
            r_null_seen <= w_null_cond;
            r_ill_seen  <= w_illegal;
            if (w_illegal && r_ill_seen) begin
                r_err_rail <= 1'b1;
            end
        end
    end

    // Watchdog covers waits on the core only; a stall caused by a full
    // output buffer is the consumer's doing and keeps the counter cleared.
    assign w_wd_arm = (r_state != ST_IDLE);
    assign w_wd_clr = (w_state_next != r_state) |
                      ((r_state == ST_DATA) & w_data_ok & ~w_buf_free);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_wd_clr) begin
                r_wd_cnt <= '0;
            end else if (w_wd_arm && (r_wd_cnt != WD_MAX)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_arm && (r_wd_cnt == WD_MAX)) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MULT3_W; i++) begin
            mul_a_r1[i] = r_a_dr[i].r1;
            mul_a_r0[i] = r_a_dr[i].r0;
            mul_b_r1[i] = r_b_dr[i].r1;
            mul_b_r0[i] = r_b_dr[i].r0;
        end
    end

    assign mul_ki      = r_ki;
    assign out_valid   = r_out_valid;
    assign out_p       = r_out_p;
    assign err_timeout = r_err_timeout;
    assign err_rail    = r_err_rail;

endmodule

// File: tb/tb_ncl_mult3_sync_bridge.sv
// Bench for ncl_mult3_sync_bridge with a behavioural four-phase NCL core model.
`timescale 1ns/1ps
module tb_ncl_mult3_sync_bridge;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 1023;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_a = '0;
    logic [2:0] in_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] out_p;
    logic       mul_rst;
    logic       mul_ki;
    logic [2:0] mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0;
    logic [5:0] mul_p_r1, mul_p_r0;
    logic       mul_ko = 1'b0;
    logic       err_timeout, err_rail;

    logic [5:0] core_r1 = '0;
    logic [5:0] core_r0 = '0;
    logic [5:0] inj_r1  = '0;
    logic [5:0] inj_r0  = '0;
    bit         core_freeze = 1'b0;
    bit         core_hang   = 1'b0;
    int         core_dly    = 2;
    int         core_cnt    = 0;

    int checks   = 0;
    int failures = 0;

    assign mul_p_r1 = core_r1 | inj_r1;
    assign mul_p_r0 = core_r0 | inj_r0;

    always #5 clk = ~clk;

    ncl_mult3_sync_bridge #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_p       (out_p),
        .mul_rst     (mul_rst),
        .mul_ki      (mul_ki),
        .mul_a_r1    (mul_a_r1),
        .mul_a_r0    (mul_a_r0),
        .mul_b_r1    (mul_b_r1),
        .mul_b_r0    (mul_b_r0),
        .mul_p_r1    (mul_p_r1),
        .mul_p_r0    (mul_p_r0),
        .mul_ko      (mul_ko),
        .err_timeout (err_timeout),
        .err_rail    (err_rail)
    );

    // Core model: DATA wave after core_dly cycles of complete inputs with Ki=1,
    // NULL wave after core_dly cycles of NULL inputs with Ki=0.
    always @(negedge clk) begin
        logic [5:0] prod;
        if (mul_rst) begin
            mul_ko   = 1'b1;
            core_r1  = '0;
            core_r0  = '0;
            core_cnt = 0;
        end else if (!core_freeze && !core_hang) begin
            if (mul_ki && mul_ko && ((mul_a_r1 ^ mul_a_r0) == 3'b111) &&
                ((mul_b_r1 ^ mul_b_r0) == 3'b111)) begin
                if (core_cnt >= core_dly) begin
                    prod     = 6'(mul_a_r1) * 6'(mul_b_r1);
                    core_r1  = prod;
                    core_r0  = ~prod;
                    mul_ko   = 1'b0;
                    core_cnt = 0;
                end else begin
                    core_cnt++;
                end
            end else if (!mul_ki && !mul_ko &&
                         ((mul_a_r1 | mul_a_r0 | mul_b_r1 | mul_b_r0) == 3'b000)) begin
                if (core_cnt >= core_dly) begin
                    core_r1  = '0;
                    core_r0  = '0;
                    mul_ko   = 1'b1;
                    core_cnt = 0;
                end else begin
                    core_cnt++;
                end
            end else begin
                core_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_p"},     int'(out_p), 0);
        check({tag, "_mul_ki"},    int'(mul_ki), 1);
        check({tag, "_rails"},     int'({mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0}), 0);
        check({tag, "_mul_rst"},   int'(mul_rst), 1);
        check({tag, "_err_to"},    int'(err_timeout), 0);
        check({tag, "_err_rail"},  int'(err_rail), 0);
    endtask

    task automatic wait_ready(input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (in_ready) begin got = 1'b1; break; end
        end
        check({tag, "_init_to_idle"}, int'(got), 1);
    endtask

    task automatic reset_dut(input string tag);
        @(posedge clk); #2;
        rst = 1'b1;
        core_hang   = 1'b0;
        core_freeze = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_ready(tag);
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] b, output bit ok);
        ok = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (ok) @(posedge clk);
        #1 in_valid = 1'b0;
        check("accept", int'(ok), 1);
    endtask

    task automatic recv(input int req, input string name);
        bit got = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        check({name, "_valid"}, int'(got), 1);
        if (got) check(name, int'(out_p), req);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        int         p;
    } vec_t;

    vec_t vecs[10];
    int   exp_q[$];

    initial begin
        bit ok;
        bit got;
        int n_lat;
        int pairs[64];

        vecs[0] = '{3'd5, 3'd6, 30};
        vecs[1] = '{3'd7, 3'd7, 49};
        vecs[2] = '{3'd0, 3'd7, 0};
        vecs[3] = '{3'd7, 3'd0, 0};
        vecs[4] = '{3'd1, 3'd1, 1};
        vecs[5] = '{3'd3, 3'd5, 15};
        vecs[6] = '{3'd6, 3'd6, 36};
        vecs[7] = '{3'd4, 3'd7, 28};
        vecs[8] = '{3'd2, 3'd3, 6};
        vecs[9] = '{3'd7, 3'd6, 42};

        // Reset state and mul_rst release latency
        repeat (3) @(posedge clk);
        #1 check_reset_values("por");
        @(posedge clk); #2;
        rst = 1'b0;
        #0 check("mul_rst_held", int'(mul_rst), 1);
        n_lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (!mul_rst) begin n_lat = n; break; end
        end
        check("mul_rst_latency", n_lat, SYNC_STAGES + 1);
        wait_ready("por");
        check("idle_ki", int'(mul_ki), 1);
        check("idle_rails", int'({mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0}), 0);

        // Directed 5*6 with the buffer held full so the handshake is observable
        send(3'd5, 3'd6, ok);
        check("a_rails", int'({mul_a_r1, mul_a_r0}), int'({3'd5, 3'd2}));
        check("b_rails", int'({mul_b_r1, mul_b_r0}), int'({3'd6, 3'd1}));
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (!mul_ki) begin got = 1'b1; break; end
        end
        check("ki_fall", int'(got), 1);
        check("ki_fall_rails_null", int'({mul_a_r1, mul_a_r0, mul_b_r1, mul_b_r0}), 0);
        check("ki_fall_out_valid", int'(out_valid), 1);
        check("p_5x6", int'(out_p), 30);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (mul_ki) begin got = 1'b1; break; end
        end
        check("ki_rise", int'(got), 1);
        check("ki_rise_core_null", int'({mul_ko, mul_p_r1, mul_p_r0}), int'({1'b1, 12'd0}));
        check("held_valid", int'(out_valid), 1);
        recv(30, "drain_5x6");
        check("drained", int'(out_valid), 0);

        // Table of directed vectors
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, ok);
            recv(vecs[i].p, $sformatf("vec%0d", i));
        end

        // All 64 operand pairs in random order with random stalls and core delays
        for (int i = 0; i < 64; i++) pairs[i] = i;
        for (int i = 63; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = pairs[i]; pairs[i] = pairs[j]; pairs[j] = t;
        end
        fork
            begin
                bit pok;
                for (int i = 0; i < 64; i++) begin
                    logic [2:0] a;
                    logic [2:0] b;
                    a = 3'(pairs[i] >> 3);
                    b = 3'(pairs[i]);
                    core_dly = int'($urandom_range(0, 4));
                    send(a, b, pok);
                    if (pok) exp_q.push_back(int'(a) * int'(b));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
            end
            begin
                int  rcv = 0;
                bit  ki_prev = 1'b1;
                bit  free_prev = 1'b1;
                for (int cyc = 0; cyc < 40000 && rcv < 64; cyc++) begin
                    @(negedge clk);
                    if (ki_prev && !mul_ki) check("ki_fall_needs_room", int'(free_prev), 1);
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_product", int'(out_p), -1);
                        end else begin
                            check("exh_product", int'(out_p), exp_q.pop_front());
                        end
                        rcv++;
                    end
                    ki_prev   = mul_ki;
                    free_prev = !out_valid || out_ready;
                end
                out_ready = 1'b0;
                check("exh_count", rcv, 64);
            end
        join
        core_dly = 2;

        // Rail error: single-cycle glitch ignored, three-cycle fault sticks
        core_freeze = 1'b1;
        @(negedge clk);
        inj_r1[3] = 1'b1; inj_r0[3] = 1'b1;
        @(negedge clk);
        inj_r1 = '0; inj_r0 = '0;
        repeat (8) @(posedge clk);
        #1 check("rail_glitch_ignored", int'(err_rail), 0);
        @(negedge clk);
        inj_r1[3] = 1'b1; inj_r0[3] = 1'b1;
        repeat (3) @(negedge clk);
        inj_r1 = '0; inj_r0 = '0;
        repeat (8) @(posedge clk);
        #1 check("rail_err_set", int'(err_rail), 1);
        repeat (5) @(posedge clk);
        #1 check("rail_err_sticky", int'(err_rail), 1);
        reset_dut("rail");
        check("rail_err_cleared", int'(err_rail), 0);

        // Watchdog: core never acknowledges DATA
        core_hang = 1'b1;
        send(3'd3, 3'd3, ok);
        for (int n = 0; n < TIMEOUT_CYCLES - 5; n++) @(posedge clk);
        #1 check("wd_not_early", int'(err_timeout), 0);
        got = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (err_timeout) begin got = 1'b1; break; end
        end
        check("wd_fired", int'(got), 1);
        repeat (5) @(posedge clk);
        #1;
        check("wd_sticky", int'(err_timeout), 1);
        check("wd_hold_data", int'({mul_ki, in_ready, out_valid}), int'(3'b100));
        reset_dut("wd");
        check("wd_cleared", int'(err_timeout), 0);

        // Reset while in NULLP with a held product
        send(3'd6, 3'd5, ok);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (!mul_ki) begin got = 1'b1; break; end
        end
        core_freeze = 1'b1;
        check("nullp_reached", int'(got), 1);
        repeat (3) @(posedge clk);
        #1 check("nullp_held", int'({out_valid, mul_ki}), int'(2'b10));
        @(posedge clk); #3;
        rst = 1'b1;
        #1 check_reset_values("midrst");
        core_freeze = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_ready("midrst");
        send(3'd7, 3'd7, ok);
        recv(49, "after_rst_7x7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
